rv32_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide operations; these are too slow for the single-cycle ALU.
- Sits beside the ALU in the execute stage.
- Accepts one operation per valid/ready handshake and runs an iterative shift-add / restoring-divide datapath.
- Returns the result on an output valid/ready handshake; the pipeline stalls on ready_out / valid_out.

---
 rtl/rv32_muldiv_pkg.sv | 26 ++
 rtl/rv32_muldiv_step.sv | 35 +++
 rtl/rv32_muldiv_seq.sv | 208 ++++++++++++++++++++
 tb/tb_rv32_muldiv_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_muldiv_pkg.sv
// Shared definitions for the RV32M multi-cycle multiply/divide sequencer.
// Optional Q18.14 fixed-point multiply is enabled by defining RV32_MULDIV_FXMUL_EN.
package rv32_muldiv_pkg;

  // op_in encoding: [2:0] is the RV32M funct3, [3] selects the fixed-point multiply
  localparam logic [3:0] RV32_MULDIV_OP_MUL    = 4'd0;
  localparam logic [3:0] RV32_MULDIV_OP_MULH   = 4'd1;
  localparam logic [3:0] RV32_MULDIV_OP_MULHSU = 4'd2;
  localparam logic [3:0] RV32_MULDIV_OP_MULHU  = 4'd3;
  localparam logic [3:0] RV32_MULDIV_OP_DIV    = 4'd4;
  localparam logic [3:0] RV32_MULDIV_OP_DIVU   = 4'd5;
  localparam logic [3:0] RV32_MULDIV_OP_REM    = 4'd6;
  localparam logic [3:0] RV32_MULDIV_OP_REMU   = 4'd7;
  localparam logic [3:0] RV32_MULDIV_OP_FXMUL  = 4'b1000;

  // Quotient returned for a divide by zero
  localparam logic [31:0] RV32_MULDIV_EARLY_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_e;

  // Magnitude of a 32-bit operand; 0x80000000 maps to 2^31, which still fits unsigned
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/rv32_muldiv_step.sv
// One combinational iteration of the shared datapath: shift-add for multiply,
// restoring subtract-compare for divide. {hi,lo} is the 64-bit working register.
module rv32_muldiv_step (
  input  logic        is_div_in,
  input  logic [31:0] operand_in,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff;

  // Multiply: add multiplicand if lo[0], shift right. Divide: shift left, trial subtract.
  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand_in} : 33'd0);
    shifted = {hi_in, lo_in[31]};
    ge      = (shifted >= {1'b0, operand_in});
    // Remainder stays below the divisor, so the true difference fits in 32 bits
    diff    = shifted[31:0] - operand_in;
    hi_out  = '0;
    lo_out  = '0;
    if (is_div_in) begin
      hi_out = ge ? diff : shifted[31:0];
      lo_out = {lo_in[30:0], ge};
    end else begin
      hi_out = sum[32:1];
      lo_out = {sum[0], lo_in[31:1]};
    end
  end

endmodule

// File: rtl/rv32_muldiv_seq.sv
// RV32M multiply/divide sequencer beside the execute-stage ALU.
// Handshakes: an op is accepted on a clock edge where valid_in && ready_out && !flush_in;
// a result is consumed on an edge where valid_out && ready_in. result_out is stable while
// valid_out is high. flush_in aborts anything in flight and discards the result.
// Define RV32_MULDIV_FXMUL_EN to enable the Q18.14 fixed-point multiply on op_in[3].
module rv32_muldiv_seq
  import rv32_muldiv_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [3:0]  op_in,
  input  logic [31:0] rs1_value_in,
  input  logic [31:0] rs2_value_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] result_out,
  output state_e      dbg_state_out
);

  localparam int ITER  = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
  logic [2:0]         f3_q, f3_d;
  logic               is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
`ifdef RV32_MULDIV_FXMUL_EN
  logic               fx_q, fx_d;
`endif

  // Accept-side decode
  logic [2:0]  f3;
  logic        div_op, sa, sb, neg_a, neg_b, early;
  logic [31:0] mag_a, mag_b, early_val;

  // Fixup-side values
  logic [63:0] prod, prod_s;
  logic [31:0] quot, rem, fix_val;

  logic [31:0] hi_chain [BITS_PER_CYCLE+1];
  logic [31:0] lo_chain [BITS_PER_CYCLE+1];

  assign hi_chain[0] = hi_q;
  assign lo_chain[0] = lo_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    rv32_muldiv_step u_step (
      .is_div_in  (is_div_q),
      .operand_in (opnd_q),
      .hi_in      (hi_chain[i]),
      .lo_in      (lo_chain[i]),
      .hi_out     (hi_chain[i+1]),
      .lo_out     (lo_chain[i+1])
    );
  end

  // Decode the incoming op: operand signedness, magnitudes, early-out detection
  always_comb begin
    f3     = op_in[2:0];
    div_op = f3[2];
    sa     = ({1'b0, f3} == RV32_MULDIV_OP_MULH) || ({1'b0, f3} == RV32_MULDIV_OP_MULHSU) ||
             ({1'b0, f3} == RV32_MULDIV_OP_DIV)  || ({1'b0, f3} == RV32_MULDIV_OP_REM);
    sb     = ({1'b0, f3} == RV32_MULDIV_OP_MULH) ||
             ({1'b0, f3} == RV32_MULDIV_OP_DIV)  || ({1'b0, f3} == RV32_MULDIV_OP_REM);
`ifdef RV32_MULDIV_FXMUL_EN
    if (op_in[3]) begin
      sa     = 1'b1;
      sb     = 1'b1;
      div_op = 1'b0;
    end
`endif
    mag_a     = mag32(rs1_value_in, sa);
    mag_b     = mag32(rs2_value_in, sb);
    neg_a     = sa & rs1_value_in[31];
    neg_b     = sb & rs2_value_in[31];
    early     = 1'b0;
    early_val = '0;
    if (div_op && (rs2_value_in == 32'd0)) begin
      early     = 1'b1;
      early_val = f3[1] ? rs1_value_in : RV32_MULDIV_EARLY_ONES;
    end else if (div_op && sa && (rs1_value_in == 32'h8000_0000) &&
                 (rs2_value_in == RV32_MULDIV_EARLY_ONES)) begin
      early     = 1'b1;
      early_val = f3[1] ? 32'd0 : 32'h8000_0000;
    end
`ifndef RV32_MULDIV_FXMUL_EN
    // Extended op without the fixed-point option is illegal: finish at once with 0
    if (op_in[3]) begin
      early     = 1'b1;
      early_val = '0;
    end
`endif
  end

  // Sign correction and result selection applied in FIXUP
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_res_q ? (64'd0 - prod) : prod;
    quot   = neg_res_q ? (32'd0 - lo_q) : lo_q;
    rem    = neg_rem_q ? (32'd0 - hi_q) : hi_q;
    if (is_div_q)                                 fix_val = f3_q[1] ? rem : quot;
    else if ({1'b0, f3_q} == RV32_MULDIV_OP_MUL)  fix_val = prod_s[31:0];
    else                                          fix_val = prod_s[63:32];
`ifdef RV32_MULDIV_FXMUL_EN
    if (fx_q) fix_val = prod_s[45:14];
`endif
  end

  // Next-state logic; flush_in overrides every transition
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    f3_d      = f3_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
`ifdef RV32_MULDIV_FXMUL_EN
    fx_d      = fx_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_in && !flush_in) begin
          f3_d      = f3;
          is_div_d  = div_op;
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          hi_d      = '0;
          lo_d      = div_op ? mag_a : mag_b;
          opnd_d    = div_op ? mag_b : mag_a;
          count_d   = CNT_W'(ITER - 1);
`ifdef RV32_MULDIV_FXMUL_EN
          fx_d      = op_in[3];
`endif
          if (early) begin
            result_d = early_val;
            state_d  = DONE;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        hi_d    = hi_chain[BITS_PER_CYCLE];
        lo_d    = lo_chain[BITS_PER_CYCLE];
        count_d = count_q - CNT_W'(1);
        if (count_q == '0) state_d = FIXUP;
      end
      FIXUP: begin
        result_d = fix_val;
        state_d  = DONE;
      end
      DONE: begin
        if (ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_in) state_d = IDLE;
  end

  // Sequencer state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      f3_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
`ifdef RV32_MULDIV_FXMUL_EN
      fx_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      f3_q      <= f3_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
`ifdef RV32_MULDIV_FXMUL_EN
      fx_q      <= fx_d;
`endif
    end
  end

  assign ready_out     = (state_q == IDLE);
  assign valid_out     = (state_q == DONE);
  assign result_out    = result_q;
  assign dbg_state_out = state_q;

endmodule

// File: tb/tb_rv32_muldiv_seq.sv
// Directed self-checking bench for rv32_muldiv_seq.
// Builds with or without RV32_MULDIV_FXMUL_EN; BPC must match the DUT parameter.
module tb_rv32_muldiv_seq;
  import rv32_muldiv_pkg::*;

  localparam int BPC   = 1;
  localparam int ITER  = 32 / BPC;
  localparam int LAT_N = ITER + 2;

  logic        clk = 1'b0;
  logic        reset_n, flush_in, valid_in, ready_in;
  logic [3:0]  op_in;
  logic [31:0] rs1_value_in, rs2_value_in;
  logic        ready_out, valid_out;
  logic [31:0] result_out;
  state_e      dbg_state_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rv32_muldiv_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_in      (flush_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .op_in         (op_in),
    .rs1_value_in  (rs1_value_in),
    .rs2_value_in  (rs2_value_in),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .result_out    (result_out),
    .dbg_state_out (dbg_state_out)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready_out, then presents the op for exactly one accept edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output bit ok);
    int guard = 0;
    while (!ready_out && guard < 200) begin
      tick();
      guard++;
    end
    ok           = ready_out;
    op_in        = op;
    rs1_value_in = a;
    rs2_value_in = b;
    valid_in     = 1'b1;
    tick();
    valid_in     = 1'b0;
  endtask

  // lat = 1 means valid_out already high in the cycle after the accept edge
  task automatic wait_result(output int lat, output logic [31:0] res);
    lat = 1;
    while (!valid_out && lat < 200) begin
      tick();
      lat++;
    end
    res = result_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b1; flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    op_in = '0; rs1_value_in = '0; rs2_value_in = '0;
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset ready_out: got %b want 1", ready_out); end
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
    n_tests++; if (result_out !== 32'd0) begin n_fail++; $display("FAIL reset result_out: got %h want 0", result_out); end
    n_tests++; if (dbg_state_out !== IDLE) begin n_fail++; $display("FAIL reset state: got %0d want IDLE", dbg_state_out); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [3:0]  ops  [14] = '{RV32_MULDIV_OP_MUL, RV32_MULDIV_OP_MULHU, RV32_MULDIV_OP_MULHSU,
                               RV32_MULDIV_OP_MULHSU, RV32_MULDIV_OP_MULH, RV32_MULDIV_OP_MULH,
                               RV32_MULDIV_OP_DIV, RV32_MULDIV_OP_REM, RV32_MULDIV_OP_DIVU,
                               RV32_MULDIV_OP_REMU, RV32_MULDIV_OP_DIV, RV32_MULDIV_OP_REM,
                               RV32_MULDIV_OP_DIVU, RV32_MULDIV_OP_MUL};
    logic [31:0] as   [14] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h80000000, 32'hFFFFFFFF,
                               32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100, 32'd20, 32'd20,
                               32'h80000000, 32'h12345678};
    logic [31:0] bs   [14] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'h80000000, 32'h2,
                               32'd3, 32'd3, 32'd7, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'h10};
    logic [31:0] exps [14] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1, 32'h40000000, 32'hFFFFFFFF,
                               32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'd2, 32'hFFFFFFFA, 32'd2,
                               32'd0, 32'h23456780};
    bit          ok;
    int          lat;
    logic [31:0] res, exp;
    for (int i = 0; i < 14; i++) begin
      issue(ops[i], as[i], bs[i], ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL arith[%0d] accept: ready_out got 0 want 1", i); end
      exp_q.push_back(exps[i]);
      wait_result(lat, res);
      exp = exp_q.pop_front();
      n_tests++; if (res !== exp) begin n_fail++; $display("FAIL arith[%0d] result: got %h want %h", i, res, exp); end
      n_tests++; if (lat != LAT_N) begin n_fail++; $display("FAIL arith[%0d] latency: got %0d want %0d", i, lat, LAT_N); end
      tick();
    end
  endtask

  task automatic test_early_out();
    logic [3:0]  ops  [6] = '{RV32_MULDIV_OP_DIVU, RV32_MULDIV_OP_DIV, RV32_MULDIV_OP_REMU,
                              RV32_MULDIV_OP_REM, RV32_MULDIV_OP_DIV, RV32_MULDIV_OP_REM};
    logic [31:0] as   [6] = '{32'd5, 32'd5, 32'hFFFFFFF0, 32'd7, 32'h80000000, 32'h80000000};
    logic [31:0] bs   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exps [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'd7, 32'h80000000, 32'd0};
    bit          ok;
    int          lat;
    logic [31:0] res, exp;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL early[%0d] accept: ready_out got 0 want 1", i); end
      exp_q.push_back(exps[i]);
      wait_result(lat, res);
      exp = exp_q.pop_front();
      n_tests++; if (res !== exp) begin n_fail++; $display("FAIL early[%0d] result: got %h want %h", i, res, exp); end
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL early[%0d] latency: got %0d want 1", i, lat); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit          ok;
    int          lat;
    logic [31:0] res;
    ready_in = 1'b0;
    issue(RV32_MULDIV_OP_MUL, 32'h7, 32'hFFFFFFFD, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp accept: ready_out got 0 want 1"); end
    // Requests while BUSY must be ignored
    for (int i = 0; i < 3; i++) begin
      op_in = RV32_MULDIV_OP_DIVU; rs1_value_in = 32'd5; rs2_value_in = 32'd0;
      valid_in = 1'b1;
      n_tests++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL bp busy ready_out: got %b want 0", ready_out); end
      tick();
      valid_in = 1'b0;
      tick();
    end
    wait_result(lat, res);
    n_tests++; if (lat + 6 != LAT_N) begin n_fail++; $display("FAIL bp latency: got %0d want %0d", lat + 6, LAT_N); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (valid_out !== 1'b1 || result_out !== 32'hFFFFFFEB || ready_out !== 1'b0) begin
        n_fail++;
        $display("FAIL bp hold[%0d]: valid=%b result=%h ready=%b want 1 ffffffeb 0", i, valid_out, result_out, ready_out);
      end
      tick();
    end
    ready_in = 1'b1;
    tick();
    n_tests++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      n_fail++; $display("FAIL bp release: valid=%b ready=%b want 0 1", valid_out, ready_out);
    end
    tick();
    n_tests++; if (dbg_state_out !== IDLE) begin n_fail++; $display("FAIL bp idle: state %0d want IDLE", dbg_state_out); end
  endtask

  task automatic test_flush();
    bit          ok;
    int          lat;
    logic [31:0] res;
    bit          saw_valid = 1'b0;
    issue(RV32_MULDIV_OP_DIV, 32'hFFFFFFEC, 32'd3, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL flush accept: ready_out got 0 want 1"); end
    for (int i = 0; i < 9; i++) begin
      if (valid_out) saw_valid = 1'b1;
      tick();
    end
    // cycle T+10: flush together with a request that must be ignored
    flush_in = 1'b1;
    valid_in = 1'b1; op_in = RV32_MULDIV_OP_MUL; rs1_value_in = 32'd3; rs2_value_in = 32'd3;
    tick();
    flush_in = 1'b0;
    valid_in = 1'b0;
    n_tests++; if (saw_valid) begin n_fail++; $display("FAIL flush early valid: got 1 want 0"); end
    n_tests++; if (ready_out !== 1'b1 || valid_out !== 1'b0 || dbg_state_out !== IDLE) begin
      n_fail++; $display("FAIL flush idle: ready=%b valid=%b state=%0d want 1 0 IDLE", ready_out, valid_out, dbg_state_out);
    end
    issue(RV32_MULDIV_OP_MUL, 32'h7, 32'hFFFFFFFD, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL flush reaccept: ready_out got 0 want 1"); end
    wait_result(lat, res);
    n_tests++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL flush mul result: got %h want ffffffeb", res); end
    n_tests++; if (lat != LAT_N) begin n_fail++; $display("FAIL flush mul latency: got %0d want %0d", lat, LAT_N); end
    tick();
    // flush while a result waits in DONE
    ready_in = 1'b0;
    issue(RV32_MULDIV_OP_DIVU, 32'd5, 32'd0, ok);
    n_tests++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL flush done pre: valid got %b want 1", valid_out); end
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    n_tests++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      n_fail++; $display("FAIL flush done: valid=%b ready=%b want 0 1", valid_out, ready_out);
    end
    ready_in = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit          ok;
    int          lat;
    logic [31:0] res;
    issue(RV32_MULDIV_OP_DIVU, 32'd100, 32'd7, ok);
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (ready_out !== 1'b1 || valid_out !== 1'b0 || result_out !== 32'd0 || dbg_state_out !== IDLE) begin
      n_fail++;
      $display("FAIL reset mid: ready=%b valid=%b result=%h state=%0d want 1 0 0 IDLE", ready_out, valid_out, result_out, dbg_state_out);
    end
    #1 reset_n = 1'b1;
    tick();
    repeat (3) begin
      n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset mid no result: valid got %b want 0", valid_out); end
      tick();
    end
    issue(RV32_MULDIV_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, ok);
    wait_result(lat, res);
    n_tests++; if (res !== 32'hFFFFFFFE || lat != LAT_N) begin
      n_fail++; $display("FAIL reset mid recover: result=%h lat=%0d want fffffffe %0d", res, lat, LAT_N);
    end
    tick();
  endtask

  task automatic test_fxmul();
    bit          ok;
    int          lat;
    logic [31:0] res;
`ifdef RV32_MULDIV_FXMUL_EN
    issue(RV32_MULDIV_OP_FXMUL, 32'h00008000, 32'h00008000, ok);
    wait_result(lat, res);
    n_tests++; if (res !== 32'h00010000 || lat != LAT_N) begin
      n_fail++; $display("FAIL fxmul 2x2: result=%h lat=%0d want 00010000 %0d", res, lat, LAT_N);
    end
    tick();
    issue(RV32_MULDIV_OP_FXMUL, 32'hFFFF8000, 32'h00008000, ok);
    wait_result(lat, res);
    n_tests++; if (res !== 32'hFFFF0000 || lat != LAT_N) begin
      n_fail++; $display("FAIL fxmul -2x2: result=%h lat=%0d want ffff0000 %0d", res, lat, LAT_N);
    end
    tick();
`else
    issue(RV32_MULDIV_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, ok);
    wait_result(lat, res);
    tick();
    issue(RV32_MULDIV_OP_FXMUL, 32'h00008000, 32'h00008000, ok);
    wait_result(lat, res);
    n_tests++; if (res !== 32'd0 || lat != 1) begin
      n_fail++; $display("FAIL illegal op: result=%h lat=%0d want 00000000 1", res, lat);
    end
    tick();
    issue(4'b1101, 32'd5, 32'd0, ok);
    wait_result(lat, res);
    n_tests++; if (res !== 32'd0 || lat != 1) begin
      n_fail++; $display("FAIL illegal divu: result=%h lat=%0d want 00000000 1", res, lat);
    end
    tick();
`endif
    n_tests++; if (!ok) begin n_fail++; $display("FAIL fx accept: ready_out got 0 want 1"); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_arith();
    test_early_out();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_fxmul();
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
